fp_to_fix: RTL and testbench

FP_TO_FIX -- requirements
Module: fp_to_fix

---
 rtl/fp_to_fix.sv | 153 +++++++++++++++
 tb/tb_fp_to_fix.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_to_fix.sv
// IEEE-754 single to signed 32-bit fixed-point converter (truncate toward zero, saturating).
// Four-state sequencer: IDLE -> DECODE -> SHIFT -> FINISH, one conversion every four cycles.
module fp_to_fix #(
   parameter int FRAC_BITS = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic [31:0] result,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        invalid,
   output logic        inexact
);

   typedef enum logic [1:0] {IDLE, DECODE, SHIFT, FINISH} state_t;
   typedef enum logic [2:0] {C_ZERO, C_NAN, C_INF, C_UNF, C_OVF, C_NORM} cls_t;

   state_t state, state_nxt;

   logic [31:0]       op_q;
   logic signed [9:0] exp_q;
   cls_t              cls_q;
   logic [31:0]       mag_q;
   logic              lost_q;

   // ---------------- sequencer ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = DECODE;
         end
         DECODE:  state_nxt = SHIFT;
         SHIFT:   state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- decode ----------------
   logic [7:0]        e_f;
   logic [22:0]       m_f;
   logic signed [9:0] exp_d;
   cls_t              cls_d;

   always_comb begin
      e_f   = op_q[30:23];
      m_f   = op_q[22:0];
      exp_d = 10'({2'b00, e_f}) - 10'd127 + 10'(FRAC_BITS);
      if (e_f == 8'd0)           cls_d = C_ZERO;
      else if (e_f == 8'hFF)     cls_d = (m_f != 23'd0) ? C_NAN : C_INF;
      else if (exp_d < 10'sd0)   cls_d = C_UNF;
      else if (exp_d >= 10'sd31) cls_d = C_OVF;
      else                       cls_d = C_NORM;
   end

   // ---------------- shift ----------------
   // Only meaningful for C_NORM (0 <= E <= 30); other classes ignore mag/lost.
   logic [23:0] sig;
   logic [31:0] mag_d;
   logic        lost_d;
   logic [4:0]  rsh;
   logic [2:0]  lsh;

   always_comb begin
      sig    = {1'b1, op_q[22:0]};
      mag_d  = '0;
      lost_d = 1'b0;
      rsh    = '0;
      lsh    = '0;
      if (exp_q >= 10'sd23) begin
         lsh   = 3'(exp_q - 10'sd23);
         mag_d = {8'd0, sig} << lsh;
      end else begin
         rsh    = 5'(10'sd23 - exp_q);
         mag_d  = {8'd0, sig >> rsh};
         lost_d = |(sig & ~(24'hFFFFFF << rsh));
      end
   end

   // ---------------- finish ----------------
   logic [31:0] res_d;
   logic        ovf_d, inv_d, inx_d;
   logic        sgn;

   always_comb begin
      sgn   = op_q[31];
      res_d = '0;
      ovf_d = 1'b0;
      inv_d = 1'b0;
      inx_d = 1'b0;
      case (cls_q)
         C_ZERO: res_d = '0;
         C_NAN: begin
            res_d = 32'h7FFF_FFFF;
            inv_d = 1'b1;
         end
         C_UNF: inx_d = 1'b1;
         C_INF, C_OVF: begin
            res_d = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
            // -2^31 exactly is representable, so it is not an overflow
            ovf_d = !(cls_q == C_OVF && sgn && exp_q == 10'sd31 && op_q[22:0] == 23'd0);
         end
         default: begin
            res_d = sgn ? -mag_q : mag_q;
            inx_d = lost_q;
         end
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (state == IDLE && start) op_q <= dataa;
      if (state == DECODE) begin
         exp_q <= exp_d;
         cls_q <= cls_d;
      end
      if (state == SHIFT) begin
         mag_q  <= mag_d;
         lost_q <= lost_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result   <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         invalid  <= 1'b0;
         inexact  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == FINISH) begin
            done     <= 1'b1;
            result   <= res_d;
            overflow <= ovf_d;
            invalid  <= inv_d;
            inexact  <= inx_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_to_fix.sv
// Scoreboard bench for fp_to_fix: FRAC_BITS=0 and FRAC_BITS=16 instances share clock and reset.
// Expected results come from a real-arithmetic model and are checked when done pulses.
module tb_fp_to_fix;

   logic        clk = 1'b0;
   logic        reset;
   logic        start0, start16;
   logic [31:0] dataa0, dataa16;
   logic [31:0] result0, result16;
   logic        busy0, busy16, done0, done16;
   logic        ovf0, ovf16, inv0, inv16, inx0, inx16;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      logic        ovf, inv, inx;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q16[$];

   fp_to_fix #(.FRAC_BITS(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .dataa(dataa0),
      .result(result0), .busy(busy0), .done(done0),
      .overflow(ovf0), .invalid(inv0), .inexact(inx0));

   fp_to_fix #(.FRAC_BITS(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .dataa(dataa16),
      .result(result16), .busy(busy16), .done(done16),
      .overflow(ovf16), .invalid(inv16), .inexact(inx16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input int f);
      exp_t   r;
      real    v;
      int     iv;
      int     e;
      r.res = '0; r.ovf = 1'b0; r.inv = 1'b0; r.inx = 1'b0; r.due = 0;
      e = int'(a[30:23]);
      if (e == 255 && a[22:0] != 0) begin
         r.res = 32'h7FFF_FFFF; r.inv = 1'b1;
      end else if (e == 255) begin
         r.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; r.ovf = 1'b1;
      end else if (e != 0) begin
         v = real'(8388608 + int'(a[22:0])) * (2.0 ** (e - 150 + f));
         if (a[31]) v = -v;
         if (v == -2147483648.0) r.res = 32'h8000_0000;
         else if (v >= 2147483648.0) begin
            r.res = 32'h7FFF_FFFF; r.ovf = 1'b1;
         end else if (v < -2147483648.0) begin
            r.res = 32'h8000_0000; r.ovf = 1'b1;
         end else begin
            iv    = $rtoi(v);
            r.res = iv;
            r.inx = (real'(iv) != v);
         end
      end
      return r;
   endfunction

   // Drives start for one sampling edge; returns in the DECODE cycle.
   task automatic issue(input bit wide, input logic [31:0] d);
      exp_t e;
      if (wide) begin start16 = 1'b1; dataa16 = d; end
      else      begin start0  = 1'b1; dataa0  = d; end
      @(posedge clk); #1;
      e     = model(d, wide ? 16 : 0);
      e.due = cyc + 3;
      if (wide) begin q16.push_back(e); start16 = 1'b0; dataa16 = ~d; end
      else      begin q0.push_back(e);  start0  = 1'b0; dataa0  = ~d; end
   endtask

   task automatic to_done();
      repeat (3) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done0) begin
         if (q0.size() == 0) chk("f0_spurious_done", 32'd1, 32'd0);
         else begin
            e = q0.pop_front();
            chk("f0_latency", 32'(cyc), 32'(e.due));
            chk("f0_result", result0, e.res);
            chk("f0_overflow", 32'(ovf0), 32'(e.ovf));
            chk("f0_invalid", 32'(inv0), 32'(e.inv));
            chk("f0_inexact", 32'(inx0), 32'(e.inx));
         end
      end
      if (done16) begin
         if (q16.size() == 0) chk("f16_spurious_done", 32'd1, 32'd0);
         else begin
            e = q16.pop_front();
            chk("f16_latency", 32'(cyc), 32'(e.due));
            chk("f16_result", result16, e.res);
            chk("f16_overflow", 32'(ovf16), 32'(e.ovf));
            chk("f16_invalid", 32'(inv16), 32'(e.inv));
            chk("f16_inexact", 32'(inx16), 32'(e.inx));
         end
      end
   end

   logic [31:0] vec0[] = '{32'h40490FDB, 32'hC0490FDB, 32'h3F000000, 32'h4F000000,
                           32'hCF000000, 32'hFF800000, 32'h7FC00000, 32'h80000000,
                           32'h00000001, 32'h4EFFFFFF, 32'h7F800000, 32'h3F800000,
                           32'hCF000001, 32'hCEFFFFFF};

   initial begin
      logic [31:0] r;
      reset = 1'b1; start0 = 1'b0; start16 = 1'b0; dataa0 = '0; dataa16 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", result0, 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_flags", {29'd0, ovf0, inv0, inx0}, 32'd0);
      chk("rst16_result", result16, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // back-to-back through the directed list
      foreach (vec0[i]) begin
         issue(1'b0, vec0[i]);
         chk("busy_decode", 32'(busy0), 32'd1);
         to_done();
      end
      @(posedge clk); #1;

      // 1.5 then -1.5 accepted in the done cycle
      issue(1'b1, 32'h3FC00000);
      to_done();
      issue(1'b1, 32'hBFC00000);
      to_done();

      // random normals near the interesting exponent range
      for (int i = 0; i < 12; i++) begin
         r = {$urandom_range(1, 0) == 1, 8'($urandom_range(170, 100)), 23'($urandom)};
         issue(1'b0, r);
         issue(1'b1, r ^ 32'h0080_0000);
         repeat (2) @(posedge clk);
         #1;
      end
      @(posedge clk); #1;

      // start while busy is ignored
      issue(1'b0, 32'h42F6E979);
      @(posedge clk); #1;
      start0 = 1'b1; dataa0 = 32'h3F800000;
      repeat (2) @(posedge clk);
      #1;
      start0 = 1'b0;
      chk("busy_done_cycle", 32'(busy0), 32'd0);
      repeat (4) @(posedge clk);
      #1;

      // reset during SHIFT aborts without done
      issue(1'b0, 32'h40490FDB);
      @(posedge clk); #1;
      reset = 1'b1;
      void'(q0.pop_back());
      @(posedge clk); #1;
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_done", 32'(done0), 32'd0);
      chk("abort_result", result0, 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done0), 32'd0);
      issue(1'b0, 32'hC0490FDB);
      to_done();

      for (int i = 0; i < 20 && (q0.size() != 0 || q16.size() != 0); i++) @(posedge clk);
      #1;
      chk("drain0", 32'(q0.size()), 32'd0);
      chk("drain16", 32'(q16.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
